// File: rtl/sprite_arb_pkg.sv
// Shared defaults and types for the sprite ROM arbiter slice.
// Optional build macro used by this slice: SPRITE_ARB_FIXED_PRI_EN.
package sprite_arb_pkg;
  localparam int NUM_REQ     = 4;
  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 8;
  localparam int ROM_LATENCY = 1;
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0]   req_idx_t;
  typedef logic [NUM_REQ-1:0] onehot_t;
endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side and ROM-side signals of the shared sprite ROM port.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = sprite_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = sprite_arb_pkg::ADDR_W,
  parameter int DATA_W  = sprite_arb_pkg::DATA_W
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]             gnt;
  logic [ADDR_W-1:0]              rom_addr;
  logic [DATA_W-1:0]              rom_data;
  logic [DATA_W-1:0]              rdata;
  logic [NUM_REQ-1:0]             rvalid;

  // Arbiter view.
  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_addr, rdata, rvalid
  );

  // Requesters plus ROM view.
  modport master (
    output req, addr, rom_data,
    input  gnt, rom_addr, rdata, rvalid
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational rotate-priority picker: first asserted req at or after ptr wins.
module rr_picker #(
  parameter int N  = sprite_arb_pkg::NUM_REQ,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int pos;
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM between NUM_REQ pixel requesters.
// Build macro SPRITE_ARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = sprite_arb_pkg::NUM_REQ,
  parameter int ADDR_W  = sprite_arb_pkg::ADDR_W,
  parameter int DATA_W  = sprite_arb_pkg::DATA_W
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;

  logic [NUM_REQ-1:0] tag1, tag2;
  logic               v1, v2;
  logic [ADDR_W-1:0]  rom_addr_q;

  rr_picker #(.N(NUM_REQ), .IW(IDX_W)) u_picker (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (win_idx),
    .any (pick_any)
  );

  // Grants are suppressed for the whole reset window, not just at the flops.
  assign bus.gnt = Reset_n ? pick_gnt : '0;

`ifdef SPRITE_ARB_FIXED_PRI_EN
  assign ptr = '0;
`else
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!Reset_n) begin
      ptr <= '0;
    end else if (pick_any) begin
      ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // Stage 1 launches the ROM read; stage 2 lines the tag up with the ROM's registered output.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= '0;
      tag1       <= '0;
      v1         <= 1'b0;
      tag2       <= '0;
      v2         <= 1'b0;
    end else begin
      if (pick_any) begin
        rom_addr_q <= bus.addr[win_idx];
        tag1       <= pick_gnt;
      end
      v1   <= pick_any;
      tag2 <= tag1;
      v2   <= v1;
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.rvalid   = v2 ? tag2 : '0;
  assign bus.rdata    = v2 ? bus.rom_data : '0;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Table-driven bench for sprite_rom_arbiter with a ROM model and a read-return scoreboard.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  localparam bit FIXED =
`ifdef SPRITE_ARB_FIXED_PRI_EN
    1'b1;
`else
    1'b0;
`endif

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {a[14:8], 1'b0} ^ {5'd0, a[18:16]} ^ 8'h3C;
  endfunction

  // Synchronous ROM with one-cycle registered read.
  always @(posedge Clk) bus.rom_data <= rom_fn(bus.rom_addr);

  typedef struct {
    logic              rst_n;
    onehot_t           req;
    logic [ADDR_W-1:0] base;
    onehot_t           exp_gnt;
  } vec_t;

  typedef struct {
    int                due;
    onehot_t           tag;
    logic [DATA_W-1:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [ADDR_W-1:0] m_rom_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic r, input onehot_t q, input logic [ADDR_W-1:0] b,
                     input onehot_t e_rr, input onehot_t e_fx);
    vec_t v;
    v.rst_n   = r;
    v.req     = q;
    v.base    = b;
    v.exp_gnt = FIXED ? e_fx : e_rr;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, check mid-cycle, then advance past the next rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    logic [ADDR_W-1:0] wa;
    Reset_n = v.rst_n;
    bus.req = v.req;
    for (int i = 0; i < NUM_REQ; i++) bus.addr[i] = v.base + ADDR_W'(i);
    @(negedge Clk);
    if (!Reset_n) begin
      sb.delete();
      m_rom_addr = '0;
    end
    check("gnt", 32'(bus.gnt), 32'(v.exp_gnt));
    check("rom_addr", 32'(bus.rom_addr), 32'(m_rom_addr));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", 32'(bus.rvalid), 32'(e.tag));
      check("rdata", 32'(bus.rdata), 32'(e.data));
    end else begin
      check("rvalid_idle", 32'(bus.rvalid), 32'd0);
      check("rdata_idle", 32'(bus.rdata), 32'd0);
    end
    if (Reset_n && v.exp_gnt != '0) begin
      wa = '0;
      for (int i = 0; i < NUM_REQ; i++)
        if (v.exp_gnt[i]) wa = v.base + ADDR_W'(i);
      m_rom_addr = wa;
      e.due  = cyc + 2;
      e.tag  = v.exp_gnt;
      e.data = rom_fn(wa);
      sb.push_back(e);
    end
    cyc++;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bus.req  = '0;
    bus.addr = '0;

    // Held in reset with every requester asserting: no grant may escape.
    add(1'b0, 4'b1111, 19'h00000, 4'b0000, 4'b0000);
    add(1'b0, 4'b1111, 19'h00000, 4'b0000, 4'b0000);
    // Single requester 2 at 0x00123, then idle so the one return is seen.
    add(1'b1, 4'b0100, 19'h00121, 4'b0100, 4'b0100);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b0000, 19'h00121, 4'b0000, 4'b0000);
    // Move the pointer back to 0, then all four held.
    add(1'b1, 4'b1000, 19'h04560, 4'b1000, 4'b1000);
    for (int k = 0; k < 8; k++)
      add(1'b1, 4'b1111, 19'h04560, onehot_t'(4'b0001 << (k % 4)), 4'b0001);
    // Grant requester 1 alone so the pointer sits at 2, then 1 and 3 held.
    add(1'b1, 4'b0010, 19'h2A0F0, 4'b0010, 4'b0010);
    for (int k = 0; k < 4; k++)
      add(1'b1, 4'b1010, 19'h2A0F0, (k % 2 == 0) ? 4'b1000 : 4'b0010, 4'b0010);
    // Idle gap: pipeline drains, rom_addr holds.
    for (int k = 0; k < 5; k++) add(1'b1, 4'b0000, 19'h2A0F0, 4'b0000, 4'b0000);
    // Requesters 0 and 1 held for ten cycles.
    for (int k = 0; k < 10; k++)
      add(1'b1, 4'b0011, 19'h51230, (k % 2 == 0) ? 4'b0001 : 4'b0010, 4'b0001);
    // Grant to 0, then reset while that read is in flight.
    add(1'b1, 4'b0001, 19'h7FF00, 4'b0001, 4'b0001);
    add(1'b0, 4'b0000, 19'h7FF00, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 19'h7FF00, 4'b0000, 4'b0000);
    // After release priority restarts at 0, then requester 3 alone.
    add(1'b1, 4'b1001, 19'h0C0C0, 4'b0001, 4'b0001);
    add(1'b1, 4'b1000, 19'h0C0C0, 4'b1000, 4'b1000);
    for (int k = 0; k < 3; k++) add(1'b1, 4'b0000, 19'h0C0C0, 4'b0000, 4'b0000);

    @(posedge Clk);
    #1;
    foreach (vecs[i]) apply(vecs[i]);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
